// File: rtl/event_ts_arbiter.sv
// ----------------------------------------------------------------------------
// event_ts_arbiter
//
// Round-robin arbiter that shares the single wall-clock timestamp capture
// path between NUM_REQ pixel/row event requesters. For each grant it pulses
// the wall clock's is_active input, captures the timestamp that comes back,
// and presents one tagged event word (requester id + timestamp) on a
// valid/ready output.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous, active-high reset
//   req_i        level request per requester, held until its ack_o pulse
//   ack_o        one-hot, single-cycle grant acknowledge
//   active_o     drives the wall clock is_active input (high in ARB only)
//   timestamp_i  wall clock timestamp
//   evt_valid_o  event word valid
//   evt_ready_i  downstream accepts the event word
//   evt_id_o     granted requester index
//   evt_ts_o     captured timestamp
//   busy_o       high whenever the arbiter is not idle
// ----------------------------------------------------------------------------
module event_ts_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int SIZE    = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] ack_o,
    output logic               active_o,
    input  logic [SIZE-1:0]    timestamp_i,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [ID_W-1:0]    evt_id_o,
    output logic [SIZE-1:0]    evt_ts_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } state_e;

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               valid_q;
    logic [ID_W-1:0]    id_q;
    logic [SIZE-1:0]    ts_q;

    logic [ID_W-1:0]    winner_d;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               found;

    // Round-robin pick: first set request at or above rr_ptr_q, wrapping at
    // NUM_REQ-1. The modulo keeps non-power-of-two NUM_REQ correct.
    always_comb begin
        winner_d = rr_ptr_q;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                winner_d = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = (winner_d == ID_W'(NUM_REQ - 1)) ? '0 : winner_d + 1'b1;
        ack_d    = '0;
        ack_d[winner_d] = 1'b1;
    end

    // Single FSM; ack, event word and valid are all registered here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            ts_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        grant_q  <= winner_d;
                        ack_q    <= ack_d;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ARB;
                    end
                end
                ARB: begin
                    // Wall clock latches its counter at the end of this cycle.
                    ack_q   <= '0;
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    ts_q    <= timestamp_i;
                    id_q    <= grant_q;
                    valid_q <= 1'b1;
                    state_q <= OUT;
                end
                OUT: begin
                    // id/ts are left as-is after the transfer.
                    if (evt_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign active_o    = (state_q == ARB);
    assign busy_o      = (state_q != IDLE);
    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign evt_ts_o    = ts_q;

`ifndef SYNTHESIS
    a_active_single : assert property (@(posedge clk_i) disable iff (reset_i)
        active_o |=> !active_o);
    a_ack_onehot    : assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(ack_o));
`endif

endmodule

// File: tb/tb_event_ts_arbiter.sv
module tb_event_ts_arbiter;
    localparam int N    = 8;
    localparam int SIZE = 32;
    localparam int IDW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    ack;
    logic            active;
    logic [SIZE-1:0] ts_in;
    logic            valid;
    logic            ready;
    logic [IDW-1:0]  id;
    logic [SIZE-1:0] ts_out;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    // Wall clock model: free-running counter, latched to its output on is_active.
    logic [31:0] cnt;
    logic        scr_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] wc_val(input logic [31:0] c, input logic s);
        return s ? ((c * 32'h9E3779B1) ^ 32'h5A5A0F0F) : c;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            ts_in <= '0;
        end else begin
            cnt <= cnt + 1;
            if (active) ts_in <= wc_val(cnt, scr_en);
        end
    end

    event_ts_arbiter #(.NUM_REQ(N), .SIZE(SIZE)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .ack_o(ack),
        .active_o(active), .timestamp_i(ts_in), .evt_valid_o(valid),
        .evt_ready_i(ready), .evt_id_o(id), .evt_ts_o(ts_out), .busy_o(busy)
    );

    // Leaves the bench at the negedge of cycle 0 (first cycle after reset).
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(output bit ok, input int lim);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (ack != '0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (ack !== 8'h00) begin $display("FAIL reset_ack: got %h want 00", ack); n_err++; end
        n_cmp++; if (active !== 1'b0) begin $display("FAIL reset_active: got %b want 0", active); n_err++; end
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", valid); n_err++; end
        n_cmp++; if (id !== 3'd0) begin $display("FAIL reset_id: got %0d want 0", id); n_err++; end
        n_cmp++; if (ts_out !== 32'd0) begin $display("FAIL reset_ts: got %0d want 0", ts_out); n_err++; end
        n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_err++; end
    endtask

    task automatic test_single;
        do_reset;
        ready = 1'b1;
        for (int i = 0; i < 20 && cnt != 32'd10; i++) @(negedge clk);
        req = 8'h04;
        @(negedge clk); // cycle 11
        req = 8'h00;
        n_cmp++; if (ack !== 8'h04 || active !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL single_c11: got ack=%h act=%b busy=%b want 04 1 1", ack, active, busy); n_err++; end
        @(negedge clk); // cycle 12
        n_cmp++; if (ack !== 8'h00 || active !== 1'b0 || busy !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL single_c12: got ack=%h act=%b busy=%b vld=%b want 00 0 1 0", ack, active, busy, valid); n_err++; end
        @(negedge clk); // cycle 13
        n_cmp++; if (valid !== 1'b1 || id !== 3'd2 || ts_out !== 32'd11 || busy !== 1'b1) begin
            $display("FAIL single_c13: got vld=%b id=%0d ts=%0d busy=%b want 1 2 11 1", valid, id, ts_out, busy); n_err++; end
        @(negedge clk); // cycle 14
        n_cmp++; if (busy !== 1'b0 || valid !== 1'b0 || id !== 3'd2) begin
            $display("FAIL single_c14: got busy=%b vld=%b id=%0d want 0 0 2", busy, valid, id); n_err++; end
    endtask

    task automatic test_rr_wrap;
        bit ok;
        logic [N-1:0] exp;
        do_reset;
        ready = 1'b1;
        req   = 8'h81;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 8'h01 : 8'h80;
            wait_ack(ok, 20);
            n_cmp++;
            if (!ok) begin $display("FAIL rr_wrap_timeout: grant %0d got none want %h", k, exp); n_err++; end
            else if (ack !== exp) begin $display("FAIL rr_wrap_grant%0d: got %h want %h", k, ack, exp); n_err++; end
            @(negedge clk);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_all;
        bit ok;
        logic [N-1:0] exp;
        logic [31:0] lastc;
        do_reset;
        ready = 1'b1;
        req   = 8'hFF;
        lastc = '0;
        for (int k = 0; k < 9; k++) begin
            exp = 8'h01 << (k % 8);
            wait_ack(ok, 20);
            n_cmp++;
            if (!ok) begin $display("FAIL all_timeout: grant %0d got none want %h", k, exp); n_err++; break; end
            if (ack !== exp) begin $display("FAIL all_grant%0d: got %h want %h", k, ack, exp); n_err++; end
            if (k > 0) begin
                n_cmp++; if (cnt - lastc !== 32'd4) begin
                    $display("FAIL all_spacing%0d: got %0d want 4", k, cnt - lastc); n_err++; end
            end
            lastc = cnt;
            repeat (2) @(negedge clk);
            n_cmp++; if (valid !== 1'b1 || id !== IDW'(k % 8)) begin
                $display("FAIL all_evt%0d: got vld=%b id=%0d want 1 %0d", k, valid, id, k % 8); n_err++; end
            @(negedge clk);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [31:0] ackc;
        int waited;
        do_reset;
        ready = 1'b0;
        req   = 8'h01;
        wait_ack(ok, 20);
        ackc = cnt;
        req  = 8'h10;
        waited = 0;
        while (valid !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        n_cmp++; if (valid !== 1'b1) begin $display("FAIL bp_valid_timeout: got %b want 1", valid); n_err++; end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (valid !== 1'b1 || id !== 3'd0 || ts_out !== ackc || ack !== 8'h00 || active !== 1'b0) begin
                $display("FAIL bp_hold%0d: got vld=%b id=%0d ts=%0d ack=%h act=%b want 1 0 %0d 00 0",
                         i, valid, id, ts_out, ack, active, ackc); n_err++; end
            if (i == 5) ready = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (valid !== 1'b0 || ack !== 8'h00 || busy !== 1'b0) begin
            $display("FAIL bp_release: got vld=%b ack=%h busy=%b want 0 00 0", valid, ack, busy); n_err++; end
        @(negedge clk);
        n_cmp++; if (ack !== 8'h10 || active !== 1'b1) begin
            $display("FAIL bp_pending: got ack=%h act=%b want 10 1", ack, active); n_err++; end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset;
        ready = 1'b1;
        req   = 8'h01;
        wait_ack(ok, 20);
        req = 8'h00;
        @(negedge clk); // CAPTURE
        n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL rmid_capture: got busy=%b vld=%b want 1 0", busy, valid); n_err++; end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b0 || ack !== 8'h00 || active !== 1'b0) begin
            $display("FAIL rmid_after: got vld=%b busy=%b ack=%h act=%b want 0 0 00 0", valid, busy, ack, active); n_err++; end
        reset = 1'b0;
        req   = 8'h03; // rr_ptr back at 0 means requester 0 wins
        @(negedge clk);
        n_cmp++; if (ack !== 8'h01) begin $display("FAIL rmid_ptr0: got %h want 01", ack); n_err++; end
        req = 8'h02;
        @(negedge clk);
        wait_ack(ok, 10);
        n_cmp++; if (ack !== 8'h02) begin $display("FAIL rmid_req2: got %h want 02", ack); n_err++; end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_idle;
        do_reset;
        ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++; if (active !== 1'b0 || ack !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL idle%0d: got act=%b ack=%h vld=%b busy=%b want all 0", i, active, ack, valid, busy); n_err++; end
        end
    endtask

    // Transaction-level reference: a grant is decided from the request vector
    // seen while idle, the event appears two cycles after the ack, and it
    // leaves once ready is seen with valid high.
    task automatic test_random;
        logic [N-1:0] preq, eack;
        logic prdy, mbusy, mvalid;
        int mptr, mid, lid, w;
        logic [31:0] mackc, lts;
        do_reset;
        scr_en = 1'b1;
        ready  = 1'b1;
        mbusy = 0; mvalid = 0; mptr = 0; mid = 0; lid = 0; lts = '0; mackc = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if (ack[b]) req[b] = 1'b0;
                else if (!req[b] && $urandom_range(0, 7) == 0) req[b] = 1'b1;
                else if (req[b] && $urandom_range(0, 63) == 0) req[b] = 1'b0;
            end
            ready = ($urandom_range(0, 3) != 0);
            preq = req;
            prdy = ready;
            @(negedge clk);
            if (mvalid && prdy) begin
                mvalid = 0; mbusy = 0;
            end else if (mbusy && cnt == mackc + 2) begin
                mvalid = 1; lid = mid; lts = wc_val(mackc, 1'b1);
            end else if (!mbusy && preq != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && preq[(mptr + k) % N]) w = (mptr + k) % N;
                mid = w; mptr = (w + 1) % N; mackc = cnt; mbusy = 1;
            end
            eack = (mbusy && cnt == mackc) ? (8'h01 << mid) : 8'h00;
            n_cmp++;
            if (ack !== eack || active !== (mbusy && cnt == mackc) || busy !== mbusy ||
                valid !== mvalid || id !== IDW'(lid) || ts_out !== lts) begin
                $display("FAIL rand_c%0d: got ack=%h act=%b busy=%b vld=%b id=%0d ts=%h want %h %b %b %b %0d %h",
                         c, ack, active, busy, valid, id, ts_out, eack, (mbusy && cnt == mackc), mbusy, mvalid, lid, lts);
                n_err++;
            end
        end
        req = '0;
        scr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        ready = 1'b1;
        test_reset;
        test_single;
        test_rr_wrap;
        test_all;
        test_backpressure;
        test_reset_mid;
        test_idle;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/event_ts_arbiter.md
Name: event_ts_arbiter

Overview:
- Round-robin arbiter that shares the single wall-clock timestamp capture path between NUM_REQ pixel/row event requesters.
- Sequences the wall clock's is_active input, captures the returned timestamp, and emits one tagged event word (requester id + timestamp) per grant over a valid/ready handshake.
- Sits between the pixel-array request lines and the event output FIFO/serializer.

Parameters:
- NUM_REQ, 8, number of requesters; legal range 2..64.
- SIZE, 32, timestamp width; must match the wall clock width.
- ID_W, $clog2(NUM_REQ), width of the requester id field.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  level request per requester; held until its ack_o pulse.
- ack_o  output  NUM_REQ  one-hot, one-cycle grant acknowledge.
- active_o  output  1  drives the wall clock is_active input.
- timestamp_i  input  SIZE  wall clock timestamp output.
- evt_valid_o  output  1  event word valid.
- evt_ready_i  input  1  downstream accepts the event.
- evt_id_o  output  ID_W  granted requester index.
- evt_ts_o  output  SIZE  captured timestamp.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, checked at the clock edge): state=IDLE, rr_ptr=0, ack_o=0, evt_valid_o=0, evt_id_o=0, evt_ts_o=0, active_o=0, busy_o=0.
- Reset asserted mid-transaction aborts it. Any held event is discarded. No ack_o is re-issued.
- FSM states: IDLE, ARB, CAPTURE, OUT.
- IDLE:
  - If req_i != 0, pick the winner: the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - Register grant_id=winner and ack_o=one-hot(winner).
  - Set rr_ptr=(winner+1) mod NUM_REQ, then go to ARB.
  - If req_i == 0, stay in IDLE.
- ARB:
  - active_o=1, driven combinationally from the state.
  - ack_o is high for exactly this cycle.
  - The wall clock registers its counter at the end of this cycle.
  - Next state is CAPTURE.
- CAPTURE:
  - active_o=0.
  - Register evt_ts_o<=timestamp_i, evt_id_o<=grant_id, evt_valid_o<=1.
  - Next state is OUT.
- OUT:
  - evt_valid_o, evt_id_o and evt_ts_o hold stable while evt_ready_i=0. No timeout.
  - When evt_valid_o && evt_ready_i: clear evt_valid_o and go to IDLE.
  - evt_id_o and evt_ts_o keep their last values after the transfer.
- Latency: request seen in IDLE at cycle N gives ack_o and active_o at N+1 and evt_valid_o at N+3.
  - Minimum spacing between events is 4 cycles with evt_ready_i tied high.
- Requests arriving while busy are not lost; they are arbitrated at the next IDLE.
  - A requester that drops req_i before its ack simply loses its slot.
- active_o is never high for more than one consecutive cycle.
- Only one grant is outstanding at a time.
- Fairness: with all requesters continuously active, grants follow 0,1,...,NUM_REQ-1,0,...
- Timestamp is passed through unmodified. Wrap-around is the wall clock's concern; this block does not inspect it.
- Simultaneous req_i for the rr_ptr index and others: the rr_ptr index wins.

Test Plan:
- Reset then single request: req_i=8'h04 at cycle 10, with the wall clock reset at cycle 0 in the same reset.
  - Required: ack_o=8'h04 and active_o=1 at cycle 11.
  - Required: evt_valid_o=1, evt_id_o=2, evt_ts_o=11 at cycle 13; busy_o high cycles 11-13; IDLE at 14.
- Round-robin wrap: req_i=8'h81 held, re-asserting after each ack.
  - Required: grant order 0,7,0,7, and rr_ptr wraps 0→1→0→1.
- All requesters (8'hFF) continuously active, evt_ready_i=1.
  - Required: evt_id_o sequence 0..7 then 0, events every 4 cycles.
- Backpressure: evt_ready_i=0 for 5 cycles in OUT.
  - Required: evt_valid_o, evt_id_o, evt_ts_o stable; no new ack_o; active_o=0.
  - Required: a pending req_i=8'h10 is granted one cycle after the transfer completes.
- Reset mid-transaction: assert reset_i in CAPTURE.
  - Required: next cycle evt_valid_o=0, busy_o=0, rr_ptr=0; a following req_i=8'h02 gets ack_o=8'h02.
- No requests: req_i=0 for 100 cycles.
  - Required: active_o, ack_o, evt_valid_o and busy_o remain 0 throughout.
